// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register
// pending-write scoreboard.
//
// Ports (all on clk, rst synchronous active-high):
//   wr_en   [NUM_WR]         per-port write enable
//   wr_adr  [NUM_WR*ADDR_W]  write address, port i at [i*ADDR_W +: ADDR_W]
//   wr_data [NUM_WR*DATA_W]  write data, port i at [i*DATA_W +: DATA_W]
//   rd_en   [NUM_RD]         per-port read enable
//   rd_adr  [NUM_RD*ADDR_W]  read addresses
//   rd_data [NUM_RD*DATA_W]  registered read data (holds when rd_en=0)
//   rd_valid[NUM_RD]         one-cycle pulse after an accepted read
//   rd_busy [NUM_RD]         registered pending-write flag of the register read
//   rsv_en / rsv_adr         mark a destination register as pending
//
// Build option: define REGFILE_BYPASS_EN for write-first reads (a read that
// collides with a same-cycle write returns the write data). Without it reads
// are read-first and return the pre-edge contents and busy bit.

// One read lane: captures the selected data/busy on an accepted read and
// pulses valid for one cycle.
module regfile_mp_rd_lane #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              busy_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en_i;
      if (en_i) begin
        data_q <= data_i;
        busy_q <= busy_i;
      end
    end
  end

  assign data_o  = data_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_adr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_adr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_adr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Ports are applied in ascending order so the highest index wins a
  // same-address collision; the reserve is applied last so a new producer
  // keeps the register busy even when the old one writes back this cycle.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && !is_zero(wr_adr[w*ADDR_W +: ADDR_W])) begin
        mem_d[wr_adr[w*ADDR_W +: ADDR_W]]  = wr_data[w*DATA_W +: DATA_W];
        busy_d[wr_adr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_en && !is_zero(rsv_adr)) busy_d[rsv_adr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt;

    assign ra = rd_adr[r*ADDR_W +: ADDR_W];

    always_comb begin
      data_nxt = mem_q[ra];
      busy_nxt = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      // Forward the highest-index colliding write; its clear applies unless
      // a same-cycle reserve re-marks the register.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_adr[w*ADDR_W +: ADDR_W] == ra)) begin
          data_nxt = wr_data[w*DATA_W +: DATA_W];
          busy_nxt = rsv_en && (rsv_adr == ra);
        end
      end
`endif
      if (is_zero(ra)) begin
        data_nxt = '0;
        busy_nxt = 1'b0;
      end
    end

    regfile_mp_rd_lane #(.DATA_W(DATA_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_i    (rd_en[r]),
      .data_i  (data_nxt),
      .busy_i  (busy_nxt),
      .data_o  (rd_data[r*DATA_W +: DATA_W]),
      .valid_o (rd_valid[r]),
      .busy_o  (rd_busy[r])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed, table-driven bench for regfile_mp (2 read ports, 2 write ports).
// Each table row is one clock cycle of stimulus plus the outputs expected
// right after that edge.
module tb_regfile_mp;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_adr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_adr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_busy;
  logic        rsv_en;
  logic [4:0]  rsv_adr;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_adr(rsv_adr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rv;
    logic [4:0]  rva;
    logic [1:0]  ev;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                     input logic [4:0] wa1, input logic [31:0] wd1,
                     input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic rv, input logic [4:0] rva,
                     input logic [1:0] ev, input logic [31:0] ed0, input logic [31:0] ed1,
                     input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.rv = rv; v.rva = rva;
    v.ev = ev; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [1:0] ev, input logic [31:0] ed0,
                         input logic [31:0] ed1, input logic [1:0] eb);
    n_vec++;
    chk("rd_valid", idx, {30'd0, rd_valid}, {30'd0, ev});
    chk("rd_data0", idx, rd_data[31:0], ed0);
    chk("rd_data1", idx, rd_data[63:32], ed1);
    chk("rd_busy",  idx, {30'd0, rd_busy}, {30'd0, eb});
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_adr = '0; wr_data = '0;
    rd_en = '0; rd_adr = '0; rsv_en = 1'b0; rsv_adr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset-state reads of every non-zero register.
    for (int a = 1; a < 32; a++)
      add(2'b00, 0, 0, 0, 0, 2'b11, 5'(a), 5'(a), 0, 0, 2'b11, 0, 0, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    // r5 write then dual-port read.
    add(2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b11, 5, 5, 0, 0, 2'b11, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    // r0: write + reserve dropped.
    add(2'b01, 0, 32'h1234, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 2'b11, 0, 0, 2'b00);
    // r7 read/write collision.
    add(2'b01, 7, 32'h11, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00);
    add(2'b01, 7, 32'hA5A5A5A5, 0, 0, 2'b11, 7, 5, 0, 0, 2'b11,
        BYP ? 32'hA5A5A5A5 : 32'h11, 32'hDEADBEEF, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b01, 7, 0, 0, 0, 2'b01, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00);
    // r3 scoreboard.
    add(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 3, 2'b00, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b10, 0, 3, 0, 0, 2'b10, 32'hA5A5A5A5, 0, 2'b10);
    add(2'b01, 3, 32'h42, 0, 0, 2'b01, 3, 0, 1, 3, 2'b01, BYP ? 32'h42 : 32'h0, 0, 2'b11);
    add(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 2'b11, 32'h42, 32'h42, 2'b11);
    add(2'b01, 3, 32'h77, 0, 0, 2'b10, 0, 3, 0, 0, 2'b10, 32'h42,
        BYP ? 32'h77 : 32'h42, BYP ? 2'b01 : 2'b11);
    add(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 2'b11, 32'h77, 32'h77, 2'b00);
    // Dual write same address: port 1 wins.
    add(2'b11, 9, 32'h1, 9, 32'h2, 2'b00, 0, 0, 0, 0, 2'b00, 32'h77, 32'h77, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 2'b11, 32'h2, 32'h2, 2'b00);
    // Dual write different addresses.
    add(2'b11, 11, 32'hAAAA, 12, 32'hBBBB, 2'b00, 0, 0, 0, 0, 2'b00, 32'h2, 32'h2, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b11, 12, 11, 0, 0, 2'b11, 32'hBBBB, 32'hAAAA, 2'b00);
    // Double reserve of r4, cleared by write port 1.
    add(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 4, 2'b00, 32'hBBBB, 32'hAAAA, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b01, 4, 0, 1, 4, 2'b01, 0, 32'hAAAA, 2'b01);
    add(2'b10, 0, 0, 4, 32'h99, 2'b00, 0, 0, 0, 0, 2'b00, 0, 32'hAAAA, 2'b01);
    add(2'b00, 0, 0, 0, 0, 2'b11, 4, 4, 0, 0, 2'b11, 32'h99, 32'h99, 2'b00);
    // Dual write colliding with a read: highest port forwarded when bypassing.
    add(2'b11, 9, 32'h5, 9, 32'h6, 2'b01, 9, 0, 0, 0, 2'b01, BYP ? 32'h6 : 32'h2, 32'h99, 2'b00);
    add(2'b00, 0, 0, 0, 0, 2'b10, 0, 9, 0, 0, 2'b10, BYP ? 32'h6 : 32'h2, 32'h6, 2'b00);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all(-1, 2'b00, 0, 0, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      wr_en   = vq[i].we;
      wr_adr  = {vq[i].wa1, vq[i].wa0};
      wr_data = {vq[i].wd1, vq[i].wd0};
      rd_en   = vq[i].re;
      rd_adr  = {vq[i].ra1, vq[i].ra0};
      rsv_en  = vq[i].rv;
      rsv_adr = vq[i].rva;
      @(posedge clk);
      #1;
      chk_all(i, vq[i].ev, vq[i].ed0, vq[i].ed1, vq[i].eb);
    end

    // Reset arriving with a read and a write in the same cycle.
    wr_en = 2'b01; wr_adr = {5'd0, 5'd9}; wr_data = {32'd0, 32'h55};
    rd_en = 2'b11; rd_adr = {5'd9, 5'd9}; rsv_en = 1'b1; rsv_adr = 5'd9;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all(1000, 2'b00, 0, 0, 2'b00);
    rst = 1'b0;
    idle_inputs();
    rd_en = 2'b11; rd_adr = {5'd5, 5'd9};
    @(posedge clk);
    #1;
    chk_all(1001, 2'b11, 0, 0, 2'b00);
    idle_inputs();
    @(posedge clk);
    #1;
    chk_all(1002, 2'b00, 0, 0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
